// File: rtl/flag_selector_if.sv
// Handshake bundle between the pin/sync side and the flag selector controller.
interface flag_selector_if;
    logic       frame_start;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [7:0] count;
    logic [7:0] selector;
    logic       changed;

    modport master (
        output frame_start, btn_next, btn_prev, auto_en, count,
        input  selector, changed
    );

    modport slave (
        input  frame_start, btn_next, btn_prev, auto_en, count,
        output selector, changed
    );
endinterface

// File: rtl/flag_selector.sv
// Flag index controller: debounced next/prev buttons plus slideshow timer,
// resolved once per frame into a wrapping 8-bit selector.
module flag_selector_debounce #(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic raw,
    output logic press
);
    localparam logic [3:0] RUN_LAST = 4'(DEBOUNCE_FRAMES - 1);

    logic [1:0] sync;
    logic       stable;
    logic [3:0] run;
    logic       flip;

    // Level has disagreed with the stable state long enough to be accepted.
    assign flip  = frame_start && (sync[1] != stable) && (run == RUN_LAST);
    assign press = flip && sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            run    <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (frame_start) begin
                if (sync[1] == stable) begin
                    run <= '0;
                end else if (flip) begin
                    stable <= sync[1];
                    run    <= '0;
                end else begin
                    run <= run + 4'd1;
                end
            end
        end
    end
endmodule

module flag_selector #(
    parameter int FRAMES_PER_FLAG = 180,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input logic            clk,
    input logic            rst_n,
    flag_selector_if.slave bus
);
    localparam int         NUM_BTN   = 2;
    localparam logic [15:0] AUTO_LAST = 16'(FRAMES_PER_FLAG - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    logic [15:0]        auto_cnt;
    logic               auto_ev;
    logic               any_press;
    logic               do_next;
    logic               do_prev;
    logic [8:0]         sel_inc;
    logic [7:0]         sel_q;
    logic [7:0]         sel_nxt;
    logic [7:0]         sel_prv;
    logic [7:0]         sel_new;
    logic               chg_q;

    // Index 0 is next, index 1 is prev.
    assign raw = {bus.btn_prev, bus.btn_next};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        flag_selector_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_start (bus.frame_start),
            .raw         (raw[i]),
            .press       (press[i])
        );
    end

    assign any_press = |press;
    // Any manual press, even a cancelled pair, pre-empts the slideshow tick.
    assign auto_ev   = bus.auto_en && bus.frame_start && (auto_cnt == AUTO_LAST) && !any_press;
    assign do_next   = (press[0] && !press[1]) || auto_ev;
    assign do_prev   = press[1] && !press[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!bus.auto_en) begin
            auto_cnt <= '0;
        end else if (bus.frame_start) begin
            if (any_press || auto_cnt == AUTO_LAST) auto_cnt <= '0;
            else                                    auto_cnt <= auto_cnt + 16'd1;
        end
    end

    // Nine-bit increment so selector=255 does not alias to 0 before the compare.
    assign sel_inc = {1'b0, sel_q} + 9'd1;
    assign sel_nxt = (sel_inc < {1'b0, bus.count}) ? sel_inc[7:0] : 8'd0;
    assign sel_prv = (sel_q != 8'd0 && sel_q < bus.count) ? sel_q - 8'd1 : bus.count - 8'd1;

    always_comb begin
        sel_new = sel_q;
        if (bus.count == 8'd0) sel_new = 8'd0;
        else if (do_next)      sel_new = sel_nxt;
        else if (do_prev)      sel_new = sel_prv;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= '0;
            chg_q <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (bus.frame_start) begin
                sel_q <= sel_new;
                chg_q <= (bus.count != 8'd0) && (sel_new != sel_q);
            end
        end
    end

    assign bus.selector = sel_q;
    assign bus.changed  = chg_q;
endmodule

// File: tb/tb_flag_selector.sv
// Random and directed frame-level stimulus checked against a per-frame reference model.
module tb_flag_selector;
    localparam int FPF = 4;
    localparam int DB  = 2;
    localparam int FL  = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    // reference model state
    int stable[2];
    int run[2];
    int acnt;
    int m_sel;
    int m_chg;

    flag_selector_if bus ();

    flag_selector #(.FRAMES_PER_FLAG(FPF), .DEBOUNCE_FRAMES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        stable[0] = 0; stable[1] = 0; run[0] = 0; run[1] = 0;
        acnt = 0; m_sel = 0; m_chg = 0;
    endtask

    task automatic model_frame(input bit nb, input bit pb, input bit ae, input int cnt);
        int lv[2];
        bit pr[2];
        bit aev;
        int old;
        lv[0] = nb; lv[1] = pb;
        for (int i = 0; i < 2; i++) begin
            pr[i] = 0;
            if (lv[i] != stable[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    stable[i] = lv[i];
                    run[i]    = 0;
                    pr[i]     = (lv[i] == 1);
                end
            end else run[i] = 0;
        end
        aev = 0;
        if (!ae)                  acnt = 0;
        else if (pr[0] || pr[1])  acnt = 0;
        else if (acnt == FPF - 1) begin acnt = 0; aev = 1; end
        else                      acnt++;
        old = m_sel;
        if (cnt == 0) begin
            m_sel = 0;
            m_chg = 0;
        end else begin
            if (pr[0] && pr[1]) ;
            else if (pr[0] || (!pr[1] && aev)) m_sel = (m_sel + 1 < cnt) ? m_sel + 1 : 0;
            else if (pr[1])                    m_sel = (m_sel > 0 && m_sel < cnt) ? m_sel - 1 : cnt - 1;
            m_chg = (m_sel != old) ? 1 : 0;
        end
    endtask

    // One frame: levels held from here to the frame_start edge, optional short glitch mid-frame.
    task automatic run_frame(input bit nb, input bit pb, input bit ae, input int cnt, input bit glitch);
        bus.btn_next = nb; bus.btn_prev = pb; bus.auto_en = ae; bus.count = 8'(cnt);
        for (int c = 0; c < FL - 1; c++) begin
            if (glitch && c == 2) begin bus.btn_next = !nb; bus.btn_prev = !pb; end
            if (glitch && c == 3) begin bus.btn_next = nb;  bus.btn_prev = pb;  end
            @(negedge clk);
            chk("hold_sel", 32'(bus.selector), 32'(m_sel));
            chk("hold_chg", 32'(bus.changed), 32'd0);
        end
        bus.frame_start = 1'b1;
        model_frame(nb, pb, ae, cnt);
        @(negedge clk);
        bus.frame_start = 1'b0;
        chk("frame_sel", 32'(bus.selector), 32'(m_sel));
        chk("frame_chg", 32'(bus.changed), 32'(m_chg));
    endtask

    task automatic press(input bit nb, input bit pb, input int cnt);
        run_frame(nb, pb, 1'b0, cnt, 1'b0);
        run_frame(nb, pb, 1'b0, cnt, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, cnt, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, cnt, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.btn_next = i[0];
            bus.btn_prev = !i[0];
            @(negedge clk);
            chk("rst_sel", 32'(bus.selector), 32'd0);
            chk("rst_chg", 32'(bus.changed), 32'd0);
        end
        rst_n = 1'b1;
        bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
        @(negedge clk);
        chk("rel_sel", 32'(bus.selector), 32'd0);
        chk("rel_chg", 32'(bus.changed), 32'd0);
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit rn, rp, ra;
        int rc;
        rst_n = 1'b0;
        bus.frame_start = 1'b0; bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
        bus.auto_en = 1'b0; bus.count = 8'd52;
        model_reset();
        @(negedge clk);
        do_reset();

        // debounce: long hold gives one step, single-frame pulse and glitches give none
        for (int f = 0; f < 5; f++) run_frame(1'b1, 1'b0, 1'b0, 52, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b0, 1'b0, 52, 1'b1);
        chk("db_one_step", 32'(bus.selector), 32'd1);
        run_frame(1'b1, 1'b0, 1'b0, 52, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b0, 1'b0, 52, 1'b0);
        chk("db_short", 32'(bus.selector), 32'd1);

        // wrap at 52, then shrink count under a large selector
        press(1'b0, 1'b1, 52);
        press(1'b0, 1'b1, 52);
        chk("wrap_prev0", 32'(bus.selector), 32'd51);
        press(1'b1, 1'b0, 52);
        chk("wrap_next", 32'(bus.selector), 32'd0);
        press(1'b0, 1'b1, 52);
        press(1'b1, 1'b0, 10);
        chk("shrink_next", 32'(bus.selector), 32'd0);
        press(1'b0, 1'b1, 10);
        chk("shrink_prev", 32'(bus.selector), 32'd9);
        for (int k = 0; k < 4; k++) press(1'b0, 1'b1, 10);
        chk("count10_sel5", 32'(bus.selector), 32'd5);
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("count0", 32'(bus.selector), 32'd0);
        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 1);

        // slideshow: 12 frames, then drop enable and confirm the counter was cleared
        for (int f = 0; f < 12; f++) run_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);
        chk("auto_12", 32'(bus.selector), 32'd0);
        for (int f = 0; f < 6; f++) run_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);
        for (int f = 0; f < 6; f++) run_frame(1'b0, 1'b0, 1'b0, 3, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);
        chk("auto_cleared", 32'(bus.selector), 32'd1);
        run_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);

        // both buttons accepted on the auto tick: cancel, counter restarts
        for (int f = 0; f < 2; f++) run_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);
        run_frame(1'b1, 1'b1, 1'b1, 3, 1'b0);
        run_frame(1'b1, 1'b1, 1'b1, 3, 1'b0);
        chk("cancel_sel", 32'(bus.selector), 32'd2);
        for (int f = 0; f < 5; f++) run_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);

        // random frames with a reset in the middle
        rn = 0; rp = 0; ra = 0; rc = 52;
        for (int f = 0; f < 160; f++) begin
            if (f == 80) do_reset();
            if ($urandom_range(0, 2) == 0) rn = !rn;
            if ($urandom_range(0, 2) == 0) rp = !rp;
            if ($urandom_range(0, 9) == 0) ra = !ra;
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 6))
                    0: rc = 0;
                    1: rc = 1;
                    2: rc = 3;
                    3: rc = 10;
                    4: rc = 52;
                    5: rc = 255;
                    default: rc = int'($urandom_range(0, 255));
                endcase
            end
            run_frame(rn, rp, ra, rc, $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/flag_selector.md
# flag_selector

Sequential controller that drives the 8-bit flag selector of the flag index mux. It turns two user buttons (next/previous) and an optional slideshow mode into a selector value that wraps within the flag count reported by the mux. It sits between the Tiny Tapeout input pins and the flag mux, clocked at the pixel clock. It updates only on frame boundaries, so the displayed flag never changes mid-frame.

## Interface
Parameters:
- FRAMES_PER_FLAG, 180: frames per flag in slideshow mode (3 s at 60 Hz); legal range 1..65535.
- DEBOUNCE_FRAMES, 2: consecutive equal frame-rate samples needed to accept a button level change; legal range 1..15.

Ports:
- clk  input  1  pixel clock; single clock domain.
- rst_n  input  1  reset; synchronous, active-low.
- frame_start  input  1  one-cycle pulse at the start of each frame, from the VGA sync generator.
- btn_next  input  1  asynchronous raw button, active-high.
- btn_prev  input  1  asynchronous raw button, active-high.
- auto_en  input  1  slideshow enable; level, assumed synchronous.
- count  input  8  number of flags available (from the mux).
- selector  output  8  current flag index, registered.
- changed  output  1  one-cycle pulse; high in the cycle after selector takes a new value.

## Operation
- Synchronizers: btn_next and btn_prev each pass through a 2-FF synchronizer. Sampling below uses the second-stage value.
- Debounce, per button:
  - Keep a stable state (reset 0) and a 4-bit agreement counter (reset 0).
  - On each frame_start: if the synced level differs from the stable state, increment the counter; otherwise clear it.
  - When the counter would reach DEBOUNCE_FRAMES, flip the stable state and clear the counter.
  - A 0->1 flip of the stable state is a press event. A 1->0 flip produces no event. Holding a button gives exactly one event.
- Auto timer:
  - 16-bit frame counter, reset 0, held at 0 while auto_en=0.
  - While auto_en=1, it increments on each frame_start.
  - On the frame_start where it equals FRAMES_PER_FLAG-1, it clears and raises an auto event.
- Event resolution, evaluated only on a frame_start cycle:
  - Next press and prev press together: they cancel; no manual change.
  - Any manual press (including a cancelled pair) clears the auto counter and suppresses an auto event in the same frame.
  - Otherwise a single manual event applies. An auto event acts as "next".
- Wrap arithmetic (8-bit unsigned):
  - next: selector+1 if selector+1 < count, else 0.
  - prev: selector-1 if 0 < selector < count, else count-1 (selector=0 or selector>=count).
  - count=0: selector is forced to 0 on every frame_start; no changed pulse is generated.
- changed is asserted only if the new selector value differs from the old one. Example: count=1 with next gives 0->0, so changed stays low.

## Timing
- Reset (rst_n=0 at a rising edge): selector=0, changed=0, debounce states, counters and synchronizers all 0. Reset mid-operation takes effect at that edge and discards any pending count.
- Latency from raw button to synchronized value: 2 cycles.
- selector updates at the rising edge that samples frame_start=1 with an accepted event. changed is high for exactly the following cycle.
- No selector change ever occurs on a cycle where frame_start=0.
- From a clean press held across frames, the press is accepted on the DEBOUNCE_FRAMES-th frame_start after the synced level rises.
- Glitches shorter than one frame that are not present at a frame_start are ignored.
- Changes in count take effect at the next event. selector is never clamped spontaneously, except when count=0.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with buttons toggling -> selector=0, changed=0 throughout and on the first cycle after release.
- Debounce (DEBOUNCE_FRAMES=2, count=52): hold btn_next high over 5 frames -> selector goes 0->1 exactly once, at the 2nd frame_start after sync, with a one-cycle changed pulse. A 1-frame pulse -> no change.
- Wrap: selector=51, count=52, next -> 0. Then prev -> 51. With count reduced to 10 while selector=51: next -> 0, prev -> 9.
- Slideshow (FRAMES_PER_FLAG=4, auto_en=1, count=3): 12 frames -> selector sequence 0,1,2,0 advancing every 4th frame_start. Drop auto_en at frame 6 -> no further change and counter cleared.
- Simultaneous events: next and prev accepted on the same frame_start that is also the auto-advance frame -> selector unchanged, changed=0, auto counter restarts from 0.
- count=0 and count=1: count=0 with selector=5 -> selector=0 at the next frame_start with no changed pulse. count=1 with next presses -> selector stays 0 and changed never asserts.
